// File: rtl/dram_arbiter_pkg.sv
// Shared memory-port types, arbiter FSM states and owner encoding.
package wires;

  // Request from a requester towards memory.
  typedef struct packed {
    logic        mem_valid;
    logic        mem_instr;
    logic [1:0]  mem_mode;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
  } mem_in_type;

  // Response from memory back to a requester.
  typedef struct packed {
    logic        mem_ready;
    logic        mem_error;
    logic [31:0] mem_rdata;
  } mem_out_type;

  typedef enum logic [1:0] {
    stIdle,
    stIssue,
    stWait
  } arb_state_t;

  localparam logic OWN_INSTR = 1'b0;
  localparam logic OWN_DATA  = 1'b1;

endpackage

// File: rtl/arb_slot.sv
// Single-entry pending request register for one requester port.
module arb_slot
  import wires::*;
(
  input  logic       reset,
  input  logic       clock,
  input  mem_in_type req_in,
  input  logic       capture,
  input  logic       free,     // releases the slot once its response is delivered
  output logic       pending,
  output mem_in_type req_out
);

  // Hold the captured request until the owner's response has been returned.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pending <= 1'b0;
      req_out <= '0;
    end else if (capture) begin
      pending <= 1'b1;
      req_out <= req_in;
    end else if (free) begin
      pending <= 1'b0;
    end
  end

endmodule

// File: rtl/dram_arbiter.sv
// Two-port (instruction/data) arbiter in front of the single DRAM controller port.
// One transaction outstanding downstream; responses are routed back combinationally.
module dram_arbiter
  import wires::*;
#(
  parameter int unsigned PRIORITY = 1
) (
  input  logic        reset,
  input  logic        clock,
  input  mem_in_type  imem_in,
  output mem_out_type imem_out,
  input  mem_in_type  dmem_in,
  output mem_out_type dmem_out,
  output mem_in_type  dram_in,
  input  mem_out_type dram_out
);

  arb_state_t state_q, state_d;
  logic       owner_q, owner_d;
  logic       last_grant_q, last_grant_d;
  mem_in_type dram_q, dram_d;

  logic       i_pend, d_pend;
  mem_in_type i_req, d_req;
  logic       i_capture, d_capture;
  logic       i_free, d_free;
  logic       resp_fire;
  logic       tie;
  logic       win;

  // An occupied slot (pending or in flight) ignores further pulses.
  assign i_capture = imem_in.mem_valid & ~i_pend;
  assign d_capture = dmem_in.mem_valid & ~d_pend;

  assign resp_fire = (state_q == stWait) & dram_out.mem_ready;
  assign i_free    = resp_fire & (owner_q == OWN_INSTR);
  assign d_free    = resp_fire & (owner_q == OWN_DATA);

  arb_slot u_slot_instr (
    .reset   (reset),
    .clock   (clock),
    .req_in  (imem_in),
    .capture (i_capture),
    .free    (i_free),
    .pending (i_pend),
    .req_out (i_req)
  );

  arb_slot u_slot_data (
    .reset   (reset),
    .clock   (clock),
    .req_in  (dmem_in),
    .capture (d_capture),
    .free    (d_free),
    .pending (d_pend),
    .req_out (d_req)
  );

  // Grant selection; last_grant records the winner of the most recent contested grant.
  always_comb begin
    tie = i_pend & d_pend;
    if (tie) begin
      win = (PRIORITY != 0) ? OWN_DATA : ~last_grant_q;
    end else begin
      win = d_pend ? OWN_DATA : OWN_INSTR;
    end
  end

  // Next-state logic: select in stIdle, pulse in stIssue, wait for the response in stWait.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    dram_d       = dram_q;
    case (state_q)
      stIdle: begin
        if (i_pend | d_pend) begin
          owner_d          = win;
          dram_d           = (win == OWN_DATA) ? d_req : i_req;
          dram_d.mem_valid = 1'b0;
          if (tie) begin
            last_grant_d = win;
          end
          state_d = stIssue;
        end
      end
      stIssue: state_d = stWait;
      stWait: begin
        if (dram_out.mem_ready) begin
          state_d = stIdle;
        end
      end
      default: state_d = stIdle;
    endcase
  end

  // State, owner, arbitration history and downstream request registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= stIdle;
      owner_q      <= OWN_INSTR;
      last_grant_q <= OWN_INSTR;
      dram_q       <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      dram_q       <= dram_d;
    end
  end

  // Downstream request and owner-routed response outputs.
  always_comb begin
    dram_in           = dram_q;
    dram_in.mem_valid = (state_q == stIssue);
    imem_out          = i_free ? dram_out : '0;
    dmem_out          = d_free ? dram_out : '0;
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench: instance 0 uses fixed data priority, instance 1 round-robin.
module tb_dram_arbiter;
  import wires::*;

  logic        clock;
  logic        reset;
  mem_in_type  imem_in  [2];
  mem_out_type imem_out [2];
  mem_in_type  dmem_in  [2];
  mem_out_type dmem_out [2];
  mem_in_type  dram_in  [2];
  mem_out_type dram_out [2];

  int checks   = 0;
  int failures = 0;
  int icnt[2]   = '{0, 0};
  int dcnt[2]   = '{0, 0};
  int issues[2] = '{0, 0};

  dram_arbiter #(.PRIORITY(1)) u_dut_p1 (
    .reset    (reset),
    .clock    (clock),
    .imem_in  (imem_in[0]),
    .imem_out (imem_out[0]),
    .dmem_in  (dmem_in[0]),
    .dmem_out (dmem_out[0]),
    .dram_in  (dram_in[0]),
    .dram_out (dram_out[0])
  );

  dram_arbiter #(.PRIORITY(0)) u_dut_p0 (
    .reset    (reset),
    .clock    (clock),
    .imem_in  (imem_in[1]),
    .imem_out (imem_out[1]),
    .dmem_in  (dmem_in[1]),
    .dmem_out (dmem_out[1]),
    .dram_in  (dram_in[1]),
    .dram_out (dram_out[1])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Count delivered responses and downstream issues per instance.
  always @(posedge clock) begin
    for (int k = 0; k < 2; k++) begin
      if (imem_out[k].mem_ready) icnt[k]++;
      if (dmem_out[k].mem_ready) dcnt[k]++;
      if (dram_in[k].mem_valid) issues[k]++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic drive_i(input int k, input logic [31:0] addr);
    imem_in[k] = '{mem_valid: 1'b1, mem_instr: 1'b1, mem_mode: 2'b00, mem_addr: addr,
                   mem_wdata: 32'h0, mem_wstrb: 4'h0};
  endtask

  task automatic drive_d(input int k, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input logic [1:0] mode);
    dmem_in[k] = '{mem_valid: 1'b1, mem_instr: 1'b0, mem_mode: mode, mem_addr: addr,
                   mem_wdata: wdata, mem_wstrb: wstrb};
  endtask

  task automatic clear_reqs(input int k);
    imem_in[k] = '0;
    dmem_in[k] = '0;
  endtask

  // Advance past the pulse cycle and drop the valids.
  task automatic issue(input int k);
    step();
    clear_reqs(k);
  endtask

  // Called in the cycle after the pulse (or after the response); counts cycles to the issue.
  task automatic wait_issue(input int k, input string tag, input int exp_lat,
                            input logic [31:0] exp_addr);
    int n = 1;
    while (!dram_in[k].mem_valid && n < 20) begin
      step();
      n++;
    end
    check({tag, "_valid"}, 64'(dram_in[k].mem_valid), 64'd1);
    check({tag, "_lat"}, 64'(n), 64'(exp_lat));
    check({tag, "_addr"}, 64'(dram_in[k].mem_addr), 64'(exp_addr));
    step();
    check({tag, "_one_cycle"}, 64'(dram_in[k].mem_valid), 64'd0);
    check({tag, "_addr_held"}, 64'(dram_in[k].mem_addr), 64'(exp_addr));
  endtask

  task automatic respond(input int k, input logic [31:0] rdata, input logic err);
    dram_out[k] = '{mem_ready: 1'b1, mem_error: err, mem_rdata: rdata};
    #1;
  endtask

  task automatic finish_resp(input int k);
    step();
    dram_out[k] = '0;
    clear_reqs(k);
  endtask

  task automatic tie(input int k, input string tag, input logic data_first);
    drive_i(k, 32'h100);
    drive_d(k, 32'h200, 32'h0, 4'h0, 2'b00);
    issue(k);
    wait_issue(k, {tag, "_first"}, 2, data_first ? 32'h200 : 32'h100);
    respond(k, 32'h1111_0000, 1'b0);
    check({tag, "_first_d_rdy"}, 64'(dmem_out[k].mem_ready), 64'(data_first));
    check({tag, "_first_i_rdy"}, 64'(imem_out[k].mem_ready), 64'(!data_first));
    finish_resp(k);
    wait_issue(k, {tag, "_second"}, 2, data_first ? 32'h100 : 32'h200);
    check({tag, "_second_instr"}, 64'(dram_in[k].mem_instr), 64'(data_first));
    respond(k, 32'h2222_0000, 1'b0);
    check({tag, "_second_i_rdy"}, 64'(imem_out[k].mem_ready), 64'(data_first));
    check({tag, "_second_d_rdy"}, 64'(dmem_out[k].mem_ready), 64'(!data_first));
    finish_resp(k);
  endtask

  int i0, d0, s0;

  initial begin
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      clear_reqs(k);
      dram_out[k] = '0;
    end
    step();
    check("rst_dram_in", 64'(dram_in[0] == '0), 64'd1);
    check("rst_imem_out", 64'(imem_out[0] == '0), 64'd1);
    check("rst_dmem_out", 64'(dmem_out[0] == '0), 64'd1);
    step();
    reset = 1'b1;
    step();

    // Round-robin: data wins the first tie, instruction the repeat.
    tie(1, "rr_tie1", 1'b1);
    tie(1, "rr_tie2", 1'b0);
    // Fixed priority: data always wins.
    tie(0, "pr_tie1", 1'b1);
    tie(0, "pr_tie2", 1'b1);

    // Single read.
    drive_d(0, 32'h10, 32'h0, 4'h0, 2'b00);
    issue(0);
    wait_issue(0, "rd", 2, 32'h10);
    respond(0, 32'hDEAD_BEEF, 1'b0);
    check("rd_rdy", 64'(dmem_out[0].mem_ready), 64'd1);
    check("rd_rdata", 64'(dmem_out[0].mem_rdata), 64'hDEAD_BEEF);
    check("rd_imem_zero", 64'(imem_out[0] == '0), 64'd1);
    finish_resp(0);

    // Write with an error response.
    drive_d(0, 32'h8, 32'h1234_5678, 4'b0011, 2'b01);
    issue(0);
    wait_issue(0, "wr", 2, 32'h8);
    check("wr_wdata", 64'(dram_in[0].mem_wdata), 64'h1234_5678);
    check("wr_wstrb", 64'(dram_in[0].mem_wstrb), 64'h3);
    check("wr_mode", 64'(dram_in[0].mem_mode), 64'h1);
    respond(0, 32'h0, 1'b1);
    check("wr_rdy", 64'(dmem_out[0].mem_ready), 64'd1);
    check("wr_err", 64'(dmem_out[0].mem_error), 64'd1);
    check("wr_imem_zero", 64'(imem_out[0] == '0), 64'd1);
    finish_resp(0);

    // Data arrives while an instruction fetch is in flight.
    i0 = icnt[0];
    d0 = dcnt[0];
    drive_i(0, 32'h20);
    issue(0);
    wait_issue(0, "busy_i", 2, 32'h20);
    drive_d(0, 32'h24, 32'h0, 4'h0, 2'b00);
    issue(0);
    respond(0, 32'hA5A5_0001, 1'b0);
    check("busy_i_rdy", 64'(imem_out[0].mem_ready), 64'd1);
    check("busy_d_quiet", 64'(dmem_out[0].mem_ready), 64'd0);
    finish_resp(0);
    wait_issue(0, "busy_d", 2, 32'h24);
    respond(0, 32'hA5A5_0002, 1'b0);
    check("busy_d_rdy", 64'(dmem_out[0].mem_ready), 64'd1);
    finish_resp(0);
    check("busy_icnt", 64'(icnt[0] - i0), 64'd1);
    check("busy_dcnt", 64'(dcnt[0] - d0), 64'd1);

    // Protocol violation plus same-cycle pulses on the response cycle.
    i0 = icnt[0];
    d0 = dcnt[0];
    s0 = issues[0];
    drive_i(0, 32'h300);
    issue(0);
    wait_issue(0, "pv_i", 2, 32'h300);
    drive_i(0, 32'h304);
    issue(0);
    drive_i(0, 32'h308);
    drive_d(0, 32'h30C, 32'h0, 4'h0, 2'b00);
    respond(0, 32'hC0DE_0001, 1'b0);
    check("pv_i_rdy", 64'(imem_out[0].mem_ready), 64'd1);
    finish_resp(0);
    wait_issue(0, "pv_d", 2, 32'h30C);
    respond(0, 32'hC0DE_0002, 1'b0);
    finish_resp(0);
    for (int c = 0; c < 6; c++) step();
    check("pv_issues", 64'(issues[0] - s0), 64'd2);
    check("pv_icnt", 64'(icnt[0] - i0), 64'd1);
    check("pv_dcnt", 64'(dcnt[0] - d0), 64'd1);

    // Reset in the middle of a transaction; the late response is ignored.
    drive_d(0, 32'h50, 32'h0, 4'h0, 2'b00);
    issue(0);
    wait_issue(0, "mid", 2, 32'h50);
    reset = 1'b0;
    #1;
    check("mid_rst_dram_in", 64'(dram_in[0] == '0), 64'd1);
    reset = 1'b1;
    respond(0, 32'hBAD0_BAD0, 1'b0);
    check("mid_late_d", 64'(dmem_out[0] == '0), 64'd1);
    check("mid_late_i", 64'(imem_out[0] == '0), 64'd1);
    check("mid_late_dram_in", 64'(dram_in[0] == '0), 64'd1);
    finish_resp(0);
    drive_d(0, 32'h60, 32'h0, 4'h0, 2'b00);
    issue(0);
    wait_issue(0, "post", 2, 32'h60);
    respond(0, 32'h0000_0060, 1'b0);
    check("post_rdy", 64'(dmem_out[0].mem_ready), 64'd1);
    check("post_rdata", 64'(dmem_out[0].mem_rdata), 64'h60);
    finish_resp(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
